regfile_read_sequencer: RTL and testbench
=========================================

// Module: regfile_read_sequencer
// PURPOSE
//  Sequences operand fetch for a multicycle core whose 32x32 register bank is a 1R1W
//  synchronous macro (1-cycle read latency, read-during-write returns OLD data).
//  Accepts an rs1/rs2 request and issues two reads in fixed order. Forwards in-flight
//  writes so the returned pair is a coherent snapshot. Passes the core's write port to
//  the macro. x0 is hard-wired to zero.
// PARAMETERS
//  XLEN  32  data width
//  AW    5   register address width (5 = 32 regs, 4 = rv32e)
// PORTS
//  clk        in   1     clock, all state on rising edge
//  resetn     in   1     asynchronous, active-low reset
//  req_valid  in   1     operand fetch request
//  req_ready  out  1     high only in IDLE
//  req_rs1    in   AW    source address 1
//  req_rs2    in   AW    source address 2
//  rsp_valid  out  1     operand pair valid
//  rsp_ready  in   1     consumer accepts the pair
//  rsp_rd1    out  XLEN  rs1 value
//  rsp_rd2    out  XLEN  rs2 value
//  wr_en      in   1     core write, always accepted, no backpressure
//  wr_addr    in   AW    write address
//  wr_data    in   XLEN  write data
//  mem_re     out  1     macro read enable
//  mem_raddr  out  AW    macro read address
//  mem_rdata  in   XLEN  macro read data, valid the cycle after mem_re
//  mem_we     out  1     macro write enable
//  mem_waddr  out  AW    macro write address
//  mem_wdata  out  XLEN  macro write data
// BEHAVIOUR
//  - Reset (async, resetn=0): state=IDLE. req_ready=1 once released.
//    rsp_valid=0, rsp_rd1/rd2=0, mem_re=0, mem_raddr=0. mem_we forced 0 while resetn=0.
//  - Reset mid-operation: the transaction is dropped. No response is produced.
//  - Write path is combinational, not stalled by any state:
//    mem_we = wr_en & (wr_addr!=0); mem_waddr=wr_addr; mem_wdata=wr_data.
//  - FSM:
//    IDLE -(req_valid)-> RD1 -> RD2 -> CAP -> RESP -(rsp_ready)-> IDLE.
//    RESP holds while rsp_ready=0.
//  - Handshake: the request is taken at cycle T when req_valid&req_ready.
//    rs1 and rs2 are latched at T.
//  - RD1 (T+1): mem_re=(rs1!=0), mem_raddr=rs1.
//  - RD2 (T+2): rd1_q <= mem_rdata, or 0 if rs1==0.
//    mem_re=(rs2!=0), mem_raddr=rs2.
//  - CAP (T+3): rd2_q <= mem_rdata, or 0 if rs2==0.
//  - RESP (T+4 onward): rsp_valid=1. rsp_rd1/rd2 are registered and stable until the
//    handshake. Fixed latency is 4 cycles from acceptance to rsp_valid. Minimum request
//    spacing is 5 cycles.
//  - mem_re=0 in IDLE/CAP/RESP, and for x0 operands. rs1==rs2 still issues two reads.
//  - Coherence rule: the response equals the register state after all writes in cycles
//    <= T+3. No later write changes a held response.
//  - Forwarding for rs1: a nonzero write hit on rs1 in T+1 or T+2 replaces the captured
//    rd1 with wr_data. A hit in T+3 overwrites rd1_q. The latest write wins.
//  - Forwarding for rs2: a hit in T+2 or T+3 replaces the captured rd2 with wr_data.
//  - Writes in cycle T and earlier are visible through the macro; no forwarding is needed.
//  - Writes to x0 never forward. x0 always reads 0.
//  - rsp_valid deasserts the cycle after rsp_valid&rsp_ready. req_ready rises in that
//    same cycle.
// TESTING
//  1 reset, preload x5=0x1111_1111, x6=0x2222_2222; req rs1=5, rs2=6 at T ->
//    mem_re at T+1 (addr 5) and T+2 (addr 6); rsp_valid at T+4 with 0x11111111/0x22222222.
//  2 req rs1=0, rs2=0 -> mem_re never asserted; rsp at T+4 with 0/0.
//    wr x0=0xFFFF_FFFF in T+2 -> mem_we=0, data still 0.
//  3 x5=0xA; wr x5=0xB at T+1, then x5=0xC at T+3; req rs1=5, rs2=5 ->
//    rsp_rd1=0xC, rsp_rd2=0xC. Separately, wr x5=0xD at T+4 -> held rsp unchanged,
//    macro holds 0xD.
//  4 hold rsp_ready=0 for 10 cycles -> rsp_valid and data stable, req_ready=0.
//    Release -> next cycle rsp_valid=0, req_ready=1; next req accepted.
//  5 drop resetn for 1 cycle at T+2 -> rsp_valid=0, mem_re=0 immediately.
//    After release req_ready=1; no stale response appears.
//  6 random back-to-back reqs with random writes vs. scoreboard applying the
//    coherence rule -> zero mismatches over 10k transactions.

Source files
------------

// File: rtl/regfile_read_sequencer.sv
// Operand-fetch sequencer for a 1R1W synchronous register macro.
// Issues rs1 then rs2 reads and forwards in-flight writes so each response is a coherent snapshot.
module regfile_read_sequencer #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [AW-1:0]   req_rs1,
  input  logic [AW-1:0]   req_rs2,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rd1,
  output logic [XLEN-1:0] rsp_rd2,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  output logic            mem_re,
  output logic [AW-1:0]   mem_raddr,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            mem_we,
  output logic [AW-1:0]   mem_waddr,
  output logic [XLEN-1:0] mem_wdata
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD1  = 3'd1,
    S_RD2  = 3'd2,
    S_CAP  = 3'd3,
    S_RESP = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   rs1_q, rs1_d;
  logic [AW-1:0]   rs2_q, rs2_d;
  logic [XLEN-1:0] rd1_q, rd1_d;
  logic [XLEN-1:0] rd2_q, rd2_d;
  logic            fwd_q, fwd_d;
  logic [XLEN-1:0] fwd_data_q, fwd_data_d;
  logic            req_ready_q, req_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            mem_re_q, mem_re_d;
  logic [AW-1:0]   mem_raddr_q, mem_raddr_d;

  logic            wr_live;
  logic            hit1;
  logic            hit2;

  // Writes to x0 are discarded and never forward.
  assign wr_live = wr_en && (wr_addr != '0);
  assign hit1    = wr_live && (wr_addr == rs1_q);
  assign hit2    = wr_live && (wr_addr == rs2_q);

  assign mem_we    = wr_live && resetn;
  assign mem_waddr = wr_addr;
  assign mem_wdata = wr_data;

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rd1   = rd1_q;
  assign rsp_rd2   = rd2_q;
  assign mem_re    = mem_re_q;
  assign mem_raddr = mem_raddr_q;

  // Next-state and registered-output logic. fwd_q holds the one-cycle-old
  // write hit that the macro read could not observe (old-data on collision).
  always_comb begin
    state_d     = state_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd1_d       = rd1_q;
    rd2_d       = rd2_q;
    fwd_d       = fwd_q;
    fwd_data_d  = fwd_data_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    mem_re_d    = 1'b0;
    mem_raddr_d = mem_raddr_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          state_d     = S_RD1;
          rs1_d       = req_rs1;
          rs2_d       = req_rs2;
          req_ready_d = 1'b0;
          mem_re_d    = (req_rs1 != '0);
          mem_raddr_d = req_rs1;
        end
      end
      S_RD1: begin
        state_d     = S_RD2;
        fwd_d       = hit1;
        fwd_data_d  = wr_data;
        mem_re_d    = (rs2_q != '0);
        mem_raddr_d = rs2_q;
      end
      S_RD2: begin
        state_d = S_CAP;
        if (rs1_q == '0)   rd1_d = '0;
        else if (hit1)     rd1_d = wr_data;
        else if (fwd_q)    rd1_d = fwd_data_q;
        else               rd1_d = mem_rdata;
        fwd_d      = hit2;
        fwd_data_d = wr_data;
      end
      S_CAP: begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        fwd_d       = 1'b0;
        if (hit1) rd1_d = wr_data;
        if (rs2_q == '0)   rd2_d = '0;
        else if (hit2)     rd2_d = wr_data;
        else if (fwd_q)    rd2_d = fwd_data_q;
        else               rd2_d = mem_rdata;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b0;
        req_ready_d = 1'b1;
        fwd_d       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd1_q       <= '0;
      rd2_q       <= '0;
      fwd_q       <= 1'b0;
      fwd_data_q  <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_raddr_q <= '0;
    end else begin
      state_q     <= state_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd1_q       <= rd1_d;
      rd2_q       <= rd2_d;
      fwd_q       <= fwd_d;
      fwd_data_q  <= fwd_data_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      mem_re_q    <= mem_re_d;
      mem_raddr_q <= mem_raddr_d;
    end
  end

endmodule

// File: tb/tb_regfile_read_sequencer.sv
// Bench for regfile_read_sequencer: macro model, architectural-state reference and
// a response scoreboard checked by an independent monitor.
module tb_regfile_read_sequencer;

  logic        clk;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rd1;
  logic [31:0] rsp_rd2;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        mem_re;
  logic [4:0]  mem_raddr;
  logic [31:0] mem_rdata;
  logic        mem_we;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata;

  regfile_read_sequencer #(.XLEN(32), .AW(5)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rd1(rsp_rd1), .rsp_rd2(rsp_rd2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  typedef struct {
    logic [31:0] d1;
    logic [31:0] d2;
    int          t;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] tb_mem [32];
  logic [31:0] arch   [32];
  int          cyc;
  int          n_chk;
  int          n_fail;
  int          pend_cnt;
  logic [4:0]  pend_r1;
  logic [4:0]  pend_r2;
  int          pend_t;
  logic        last_acc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous 1R1W macro: a read colliding with a write returns the old word.
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= tb_mem[mem_raddr];
    else        mem_rdata <= $urandom;
    if (mem_we) tb_mem[mem_waddr] <= mem_wdata;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock of stimulus; the reference model sees the write of this cycle and,
  // three cycles after acceptance, snapshots the architectural registers.
  task automatic step(input logic rv, input logic [4:0] r1, input logic [4:0] r2,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic rr);
    exp_t e;
    @(posedge clk);
    #1;
    resetn    = 1'b1;
    last_acc  = rv && req_ready;
    req_valid = rv;
    req_rs1   = r1;
    req_rs2   = r2;
    wr_en     = we;
    wr_addr   = wa;
    wr_data   = wd;
    rsp_ready = rr;
    if (we && (wa != 5'd0)) arch[wa] = wd;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        e.d1 = arch[pend_r1];
        e.d2 = arch[pend_r2];
        e.t  = pend_t + 4;
        exp_q.push_back(e);
      end
    end
    if (last_acc) begin
      pend_cnt = 3;
      pend_r1  = r1;
      pend_r2  = r2;
      pend_t   = cyc;
    end
  endtask

  task automatic idle(input int n, input logic rr);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, rr);
  endtask

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 3) != 0) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  // Monitor: response latency, data, stability while stalled, write-port gating.
  initial begin : monitor
    logic        prev_v;
    logic [31:0] held1;
    logic [31:0] held2;
    prev_v = 1'b0;
    held1  = '0;
    held2  = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        prev_v = 1'b0;
      end else begin
        chk("mem_we_gate", 32'(mem_we), 32'(wr_en && (wr_addr != 5'd0)));
        if (mem_re) chk("x0_never_read", 32'(mem_raddr != 5'd0), 32'd1);
        if (rsp_valid) begin
          chk("req_ready_in_resp", 32'(req_ready), 32'd0);
          if (!prev_v) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
              chk("rsp_latency", 32'(cyc), 32'(exp_q[0].t));
              chk("rsp_rd1", rsp_rd1, exp_q[0].d1);
              chk("rsp_rd2", rsp_rd2, exp_q[0].d2);
            end
            held1 = rsp_rd1;
            held2 = rsp_rd2;
          end else begin
            chk("hold_rd1", rsp_rd1, held1);
            chk("hold_rd2", rsp_rd2, held2);
          end
          if (rsp_ready && exp_q.size() > 0) void'(exp_q.pop_front());
        end
        prev_v = rsp_valid && !rsp_ready;
      end
    end
  end

  initial begin : driver
    int n_acc;
    int guard;
    int t0;
    cyc = 0; n_chk = 0; n_fail = 0; pend_cnt = 0; last_acc = 1'b0;
    pend_r1 = '0; pend_r2 = '0; pend_t = 0; mem_rdata = '0;
    for (int i = 0; i < 32; i++) begin
      tb_mem[i] = '0;
      arch[i]   = '0;
    end
    resetn = 1'b0; req_valid = 1'b0; req_rs1 = '0; req_rs2 = '0;
    rsp_ready = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rd1", rsp_rd1, 32'd0);
    chk("rst_rd2", rsp_rd2, 32'd0);
    chk("rst_mem_re", 32'(mem_re), 32'd0);
    chk("rst_mem_raddr", 32'(mem_raddr), 32'd0);
    chk("rst_mem_we_forced", 32'(mem_we), 32'd0);
    wr_en = 1'b0;
    idle(1, 1'b1);
    chk("rst_req_ready", 32'(req_ready), 32'd1);

    // Basic fetch of two preloaded registers.
    step(1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 32'h1111_1111, 1'b1);
    step(1'b0, 5'd0, 5'd0, 1'b1, 5'd6, 32'h2222_2222, 1'b1);
    step(1'b1, 5'd5, 5'd6, 1'b0, 5'd0, 32'd0, 1'b1);
    chk("t1_idle_no_re", 32'(mem_re), 32'd0);
    idle(1, 1'b1);
    chk("t1_re1", 32'(mem_re), 32'd1);
    chk("t1_raddr1", 32'(mem_raddr), 32'd5);
    idle(1, 1'b1);
    chk("t1_re2", 32'(mem_re), 32'd1);
    chk("t1_raddr2", 32'(mem_raddr), 32'd6);
    idle(1, 1'b1);
    chk("t1_cap_no_re", 32'(mem_re), 32'd0);
    idle(1, 1'b1);
    chk("t1_valid", 32'(rsp_valid), 32'd1);
    chk("t1_rd1", rsp_rd1, 32'h1111_1111);
    chk("t1_rd2", rsp_rd2, 32'h2222_2222);
    idle(1, 1'b1);
    chk("t1_valid_drop", 32'(rsp_valid), 32'd0);
    chk("t1_req_ready", 32'(req_ready), 32'd1);

    // x0 operands and a write to x0.
    step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    idle(1, 1'b1);
    chk("t2_re_rd1", 32'(mem_re), 32'd0);
    step(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1);
    chk("t2_re_rd2", 32'(mem_re), 32'd0);
    chk("t2_x0_we", 32'(mem_we), 32'd0);
    idle(1, 1'b1);
    idle(1, 1'b1);
    chk("t2_valid", 32'(rsp_valid), 32'd1);
    chk("t2_rd1", rsp_rd1, 32'd0);
    chk("t2_rd2", rsp_rd2, 32'd0);
    idle(1, 1'b1);

    // Forwarding on rs1==rs2 and a late write after capture.
    step(1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 32'hA, 1'b1);
    step(1'b1, 5'd5, 5'd5, 1'b0, 5'd0, 32'd0, 1'b1);
    step(1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 32'hB, 1'b1);
    idle(1, 1'b0);
    step(1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 32'hC, 1'b0);
    step(1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 32'hD, 1'b0);
    chk("t3_rd1", rsp_rd1, 32'hC);
    chk("t3_rd2", rsp_rd2, 32'hC);
    idle(1, 1'b1);
    chk("t3_hold_rd1", rsp_rd1, 32'hC);
    chk("t3_macro_x5", tb_mem[5], 32'hD);
    idle(1, 1'b1);
    chk("t3_valid_drop", 32'(rsp_valid), 32'd0);

    // Long backpressure with requests and writes knocking.
    step(1'b1, 5'd5, 5'd6, 1'b0, 5'd0, 32'd0, 1'b0);
    idle(3, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 5'd7, 5'd7, 1'b1, 5'd6, 32'h5000_0000 + 32'(i), 1'b0);
      chk("t4_hold_valid", 32'(rsp_valid), 32'd1);
      chk("t4_hold_no_accept", 32'(last_acc), 32'd0);
    end
    step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    step(1'b1, 5'd6, 5'd5, 1'b0, 5'd0, 32'd0, 1'b1);
    chk("t4_rel_valid", 32'(rsp_valid), 32'd0);
    chk("t4_rel_ready", 32'(req_ready), 32'd1);
    chk("t4_next_accept", 32'(last_acc), 32'd1);
    idle(6, 1'b1);

    // Reset in the middle of a transaction drops it.
    step(1'b1, 5'd3, 5'd4, 1'b0, 5'd0, 32'd0, 1'b1);
    idle(2, 1'b1);
    resetn = 1'b0;
    #1;
    chk("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t5_mem_re", 32'(mem_re), 32'd0);
    pend_cnt = 0;
    exp_q.delete();
    idle(1, 1'b1);
    chk("t5_req_ready", 32'(req_ready), 32'd1);
    idle(8, 1'b1);

    // Randomized back-to-back traffic.
    n_acc = 0;
    guard = 0;
    while (n_acc < 10000 && guard < 90000) begin
      step(1'b1, rnd_addr(), rnd_addr(), 1'($urandom_range(0, 1)), rnd_addr(),
           $urandom, 1'($urandom_range(0, 3) != 0));
      if (last_acc) n_acc++;
      guard++;
    end
    chk("rand_txn_count", 32'(n_acc), 32'd10000);
    for (int i = 0; i < 30 && (exp_q.size() != 0 || pend_cnt != 0); i++) idle(1, 1'b1);
    idle(2, 1'b1);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
